// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and instruction memory.
//   req   : read request, held until ack
//   addr  : word-aligned fetch address, held until ack
//   ack   : read data valid this cycle (only meaningful while req=1)
//   rdata : instruction word, valid when ack=1
// master = fetch controller side, slave = memory side.
interface fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues instruction-memory
// reads and fills the IF/ID slot. Handles ID stalls with a one-word skid
// buffer and branch/jump redirects, including a redirect that arrives while
// a memory read is still outstanding (the read is drained and discarded).
// Ports:
//   clk         : clock, rising-edge active
//   rst         : asynchronous active-low reset
//   imem        : instruction-memory bus (fetch_ctrl_if.master)
//   stall       : ID hazard stall, holds the IF/ID slot
//   redirect    : taken branch/jump resolved in ID this cycle
//   redirect_pc : redirect target, low two bits ignored
//   if_valid    : IF/ID slot holds a real instruction
//   if_instr    : IF/ID instruction
//   if_pc       : address of if_instr
//   if_pcplus4  : if_pc + 4
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_ctrl_if.master       imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pcplus4
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_q, buf_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;

    logic        redirect_ok;
    logic [31:0] target;
    logic [31:0] pc_inc;

    // A redirect under stall comes from an instruction ID has not finished
    // resolving, so it only counts when the stall is low.
    assign redirect_ok = redirect & ~stall;
    assign target      = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc      = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_d        = buf_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        ifpc4_d      = ifpc4_q;
        imem.req     = 1'b0;
        imem.addr    = pc_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_ok) pc_d = target;
            end

            FETCH: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    if (redirect_ok) begin
                        // Returned word is wrong-path; refetch from the target.
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        // ID cannot take the word yet: park it in the skid buffer.
                        buf_d   = imem.rdata;
                        pc_d    = pc_inc;
                        state_d = HOLD;
                    end else begin
                        instr_d = imem.rdata;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end else if (redirect_ok) begin
                    // The read in flight cannot be cancelled on the bus, so
                    // remember its address and wait out the ack in DRAIN.
                    pc_d         = target;
                    valid_d      = 1'b0;
                    drain_addr_d = pc_q;
                    state_d      = DRAIN;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (redirect_ok) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else begin
                        // pc already advanced past the buffered word.
                        instr_d = buf_q;
                        ifpc_d  = pc_q - 32'd4;
                        ifpc4_d = pc_q;
                        valid_d = 1'b1;
                    end
                end
            end

            DRAIN: begin
                imem.req  = 1'b1;
                imem.addr = drain_addr_q;
                if (redirect_ok) pc_d = target;
                if (imem.ack) state_d = FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            buf_q        <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            ifpc_q       <= '0;
            ifpc4_q      <= 32'd4;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_q        <= buf_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            ifpc4_q      <= ifpc4_d;
        end
    end

    assign if_valid   = valid_q;
    assign if_instr   = instr_q;
    assign if_pc      = ifpc_q;
    assign if_pcplus4 = ifpc4_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table (inputs, expected
// bus request/address before the edge, expected IF/ID slot after the edge)
// plus hand-written reset sequences.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;

    fetch_ctrl_if imem ();

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pcplus4  (if_pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_slot(input int row, input logic v, input logic [31:0] ins, input logic [31:0] pc);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        chk("if_valid", row, {31'd0, if_valid}, {31'd0, v});
        chk("if_instr", row, if_instr, ins);
        chk("if_pc", row, if_pc, pc);
        chk("if_pcplus4", row, if_pcplus4, pc4);
    endtask

    // Called at a negedge; drives the row, checks the bus, clocks, checks the slot.
    task automatic step(input int row);
        vec_t v;
        v = vecs[row];
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        imem.ack    = v.ack;
        imem.rdata  = v.rdata;
        #1;
        chk("imem_req", row, {31'd0, imem.req}, {31'd0, v.exp_req});
        if (v.exp_req) chk("imem_addr", row, imem.addr, v.exp_addr);
        @(posedge clk);
        #1;
        chk_slot(row, v.exp_valid, v.exp_instr, v.exp_pc);
        @(negedge clk);
    endtask

    initial begin
        //            stall redir rpc            ack rdata          req addr           vld instr          pc
        // leave reset: IDLE -> FETCH
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_3000, 1'b0, 32'h0,         32'h0};
        // zero-wait stream
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 1'b1, 32'h0000_3000, 1'b1, 32'h1111_1111, 32'h0000_3000};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2222_2222, 1'b1, 32'h0000_3004, 1'b1, 32'h2222_2222, 32'h0000_3004};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_3333, 1'b1, 32'h0000_3008, 1'b1, 32'h3333_3333, 32'h0000_3008};
        // ack delayed 3 cycles: address held, bubbles
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_300C, 1'b0, 32'h3333_3333, 32'h0000_3008};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_300C, 1'b0, 32'h3333_3333, 32'h0000_3008};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_300C, 1'b0, 32'h3333_3333, 32'h0000_3008};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4444_4444, 1'b1, 32'h0000_300C, 1'b1, 32'h4444_4444, 32'h0000_300C};
        // stall on the ack cycle, two stalled cycles, then buffered word
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h5555_5555, 1'b1, 32'h0000_3010, 1'b1, 32'h4444_4444, 32'h0000_300C};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 32'h4444_4444, 32'h0000_300C};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h5555_5555, 32'h0000_3010};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h6666_6666, 1'b1, 32'h0000_3014, 1'b1, 32'h6666_6666, 32'h0000_3014};
        // redirect under stall ignored, then taken with same-cycle ack
        vecs[12] = '{1'b1, 1'b1, 32'h0000_5002, 1'b0, 32'h0,         1'b1, 32'h0000_3018, 1'b1, 32'h6666_6666, 32'h0000_3014};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_5002, 1'b1, 32'h7777_7777, 1'b1, 32'h0000_3018, 1'b0, 32'h6666_6666, 32'h0000_3014};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8888_8888, 1'b1, 32'h0000_5000, 1'b1, 32'h8888_8888, 32'h0000_5000};
        // redirect while request outstanding: drain, discard late ack
        vecs[15] = '{1'b0, 1'b1, 32'h0000_4001, 1'b0, 32'h0,         1'b1, 32'h0000_5004, 1'b0, 32'h8888_8888, 32'h0000_5000};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_5004, 1'b0, 32'h8888_8888, 32'h0000_5000};
        vecs[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h9999_9999, 1'b1, 32'h0000_5004, 1'b0, 32'h8888_8888, 32'h0000_5000};
        vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hAAAA_AAAA, 1'b1, 32'h0000_4000, 1'b1, 32'hAAAA_AAAA, 32'h0000_4000};
        // wrap-around at the top of the address space
        vecs[19] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hBBBB_BBBB, 1'b1, 32'h0000_4004, 1'b0, 32'hAAAA_AAAA, 32'h0000_4000};
        vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hCCCC_CCCC, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hCCCC_CCCC, 32'hFFFF_FFFC};
        vecs[21] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'hCCCC_CCCC, 32'hFFFF_FFFC};
        // successive redirects in DRAIN: last target wins
        vecs[22] = '{1'b0, 1'b1, 32'h0000_6000, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'hCCCC_CCCC, 32'hFFFF_FFFC};
        vecs[23] = '{1'b0, 1'b1, 32'h0000_7000, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'hCCCC_CCCC, 32'hFFFF_FFFC};
        vecs[24] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, 32'hCCCC_CCCC, 32'hFFFF_FFFC};
        vecs[25] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hEEEE_EEEE, 1'b1, 32'h0000_7000, 1'b1, 32'hEEEE_EEEE, 32'h0000_7000};
        // leave a request waiting for the mid-wait reset below
        vecs[26] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_7004, 1'b0, 32'hEEEE_EEEE, 32'h0000_7000};

        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem.ack    = 1'b0;
        imem.rdata  = '0;

        // Reset state, with a stray ack that must be ignored
        @(posedge clk);
        imem.ack = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_req", -1, {31'd0, imem.req}, 32'd0);
        chk("rst_addr", -1, imem.addr, 32'h0000_3000);
        chk_slot(-1, 1'b0, 32'h0, 32'h0);
        imem.ack = 1'b0;

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NVEC; i++) step(i);

        // Asynchronous reset in the middle of a pending request
        imem.ack   = 1'b1;
        imem.rdata = 32'hFEED_FACE;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req", 100, {31'd0, imem.req}, 32'd0);
        chk("midrst_addr", 100, imem.addr, 32'h0000_3000);
        chk_slot(100, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_req_hold", 101, {31'd0, imem.req}, 32'd0);
        chk_slot(101, 1'b0, 32'h0, 32'h0);

        // Restart: one IDLE cycle, then request at RESET_PC
        @(negedge clk);
        rst      = 1'b1;
        imem.ack = 1'b0;
        #1;
        chk("restart_idle_req", 102, {31'd0, imem.req}, 32'd0);
        @(posedge clk);
        #1;
        chk("restart_req", 103, {31'd0, imem.req}, 32'd1);
        chk("restart_addr", 103, imem.addr, 32'h0000_3000);
        @(negedge clk);
        imem.ack   = 1'b1;
        imem.rdata = 32'hDDDD_DDDD;
        @(posedge clk);
        #1;
        chk_slot(104, 1'b1, 32'hDDDD_DDDD, 32'h0000_3000);
        @(negedge clk);
        #1;
        chk("restart_next_addr", 105, imem.addr, 32'h0000_3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
